// File: rtl/ddr3_pkg.sv
// Shared constants, unpack state encoding and the width helper used by the gearbox.
package ddr3_pkg;

   localparam int DEF_NARROW_W = 16;
   localparam int DEF_RATIO    = 8;

   typedef enum logic {
      UP_IDLE,
      UP_BUSY
   } up_state_t;

   // Ceiling log2; clog2(RATIO+1) sizes counters that must hold the value RATIO.
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ddr3_gearbox_if.sv
// Pack and unpack handshake bundle between the gearbox and its neighbours.
interface ddr3_gearbox_if
   import ddr3_pkg::*;
#(
   parameter int NARROW_W = DEF_NARROW_W,
   parameter int RATIO    = DEF_RATIO
);

   localparam int WIDE_W = NARROW_W * RATIO;
   localparam int CNT_W  = clog2(RATIO + 1);

   logic                pk_din_vld;
   logic [NARROW_W-1:0] pk_din;
   logic                pk_din_rdy;
   logic                pk_flush;
   logic                pk_dout_vld;
   logic [WIDE_W-1:0]   pk_dout;
   logic [CNT_W-1:0]    pk_dout_cnt;
   logic                pk_dout_rdy;

   logic                up_din_vld;
   logic [WIDE_W-1:0]   up_din;
   logic                up_din_rdy;
   logic                up_dout_vld;
   logic [NARROW_W-1:0] up_dout;
   logic                up_dout_last;
   logic                up_dout_rdy;

   modport master (
      output pk_din_vld, pk_din, pk_flush, pk_dout_rdy,
      input  pk_din_rdy, pk_dout_vld, pk_dout, pk_dout_cnt,
      output up_din_vld, up_din, up_dout_rdy,
      input  up_din_rdy, up_dout_vld, up_dout, up_dout_last
   );

   modport slave (
      input  pk_din_vld, pk_din, pk_flush, pk_dout_rdy,
      output pk_din_rdy, pk_dout_vld, pk_dout, pk_dout_cnt,
      input  up_din_vld, up_din, up_dout_rdy,
      output up_din_rdy, up_dout_vld, up_dout, up_dout_last
   );

endinterface

// File: rtl/ddr3_gear_unpack.sv
// Wide-to-narrow unpacker: one wide word in, RATIO narrow beats out, zero-bubble streaming.
module ddr3_gear_unpack
   import ddr3_pkg::*;
#(
   parameter int NARROW_W  = DEF_NARROW_W,
   parameter int RATIO     = DEF_RATIO,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                         ui_clk,
   input  logic                         rst,
   input  logic                         din_vld,
   input  logic [NARROW_W*RATIO-1:0]    din,
   output logic                         din_rdy,
   output logic                         dout_vld,
   output logic [NARROW_W-1:0]          dout,
   output logic                         dout_last,
   input  logic                         dout_rdy
);

   localparam int WIDE_W = NARROW_W * RATIO;
   localparam int CNT_W  = clog2(RATIO + 1);
   localparam logic [CNT_W-1:0] PENULT_LANE = CNT_W'(RATIO - 2);

   up_state_t         state;
   logic [WIDE_W-1:0] shreg;
   logic [CNT_W-1:0]  lane;
   logic              last;
   logic              accept;
   logic              step;

   // A new word may enter when idle or while the final lane is leaving.
   always_comb begin
      din_rdy = (state == UP_IDLE) || (dout_rdy && last);
      accept  = din_vld && din_rdy;
      step    = (state == UP_BUSY) && dout_rdy;
   end

   // Lane sequencer: the current lane always sits at the output end of the shift register.
   always_ff @(posedge ui_clk or posedge rst) begin
      if (rst) begin
         state <= UP_IDLE;
         shreg <= '0;
         lane  <= '0;
         last  <= 1'b0;
      end else if (accept) begin
         state <= UP_BUSY;
         shreg <= din;
         lane  <= '0;
         last  <= 1'b0;
      end else if (step) begin
         if (last) begin
            state <= UP_IDLE;
            lane  <= '0;
            last  <= 1'b0;
         end else begin
            shreg <= MSB_FIRST ? (shreg << NARROW_W) : (shreg >> NARROW_W);
            lane  <= lane + CNT_W'(1);
            last  <= (lane == PENULT_LANE);
         end
      end
   end

   assign dout_vld  = (state == UP_BUSY);
   assign dout      = MSB_FIRST ? shreg[WIDE_W-1 -: NARROW_W] : shreg[NARROW_W-1:0];
   assign dout_last = last;

endmodule

// File: rtl/ddr3_gearbox.sv
// DDR3 user-side gearbox: narrow-to-wide packer with flush, plus an independent unpacker.
module ddr3_gearbox
   import ddr3_pkg::*;
#(
   parameter int NARROW_W  = DEF_NARROW_W,
   parameter int RATIO     = DEF_RATIO,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic          ui_clk,
   input  logic          rst,
   ddr3_gearbox_if.slave bus
);

   localparam int WIDE_W = NARROW_W * RATIO;
   localparam int CNT_W  = clog2(RATIO + 1);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RATIO);

   logic [WIDE_W-1:0] acc;
   logic [WIDE_W-1:0] acc_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [WIDE_W-1:0] dout_q;
   logic [CNT_W-1:0]  dout_cnt_q;
   logic              dout_vld_q;
   logic              flush_pend;
   logic              flush_pend_nxt;
   logic              out_free;
   logic              din_rdy;
   logic              beat;
   logic              flush_req;
   logic              emit;
   int                lane_lsb;

   // Accept/emit decision. The incoming beat is merged before any flush so a
   // coincident flush sees it; a flush that cannot emit yet is parked in flush_pend.
   always_comb begin
      out_free  = !dout_vld_q || bus.pk_dout_rdy;
      din_rdy   = (!flush_pend && (cnt != LAST_LANE)) || out_free;
      beat      = bus.pk_din_vld && din_rdy;
      flush_req = bus.pk_flush || flush_pend;
      lane_lsb  = MSB_FIRST ? (WIDE_W - (int'(cnt) + 1) * NARROW_W) : (int'(cnt) * NARROW_W);
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      if (beat) begin
         acc_nxt[lane_lsb +: NARROW_W] = bus.pk_din;
         cnt_nxt                        = cnt + CNT_W'(1);
      end
      emit           = out_free && ((cnt_nxt == FULL_CNT) || (flush_req && (cnt_nxt != '0)));
      flush_pend_nxt = !emit && flush_req && (cnt_nxt != '0);
   end

   // Accumulator, lane counter and output register; output holds until taken.
   always_ff @(posedge ui_clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         dout_q     <= '0;
         dout_cnt_q <= '0;
         dout_vld_q <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         flush_pend <= flush_pend_nxt;
         if (emit) begin
            dout_q     <= acc_nxt;
            dout_cnt_q <= cnt_nxt;
            dout_vld_q <= 1'b1;
            acc        <= '0;
            cnt        <= '0;
         end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (bus.pk_dout_rdy) begin
               dout_vld_q <= 1'b0;
            end
         end
      end
   end

   assign bus.pk_din_rdy  = din_rdy;
   assign bus.pk_dout_vld = dout_vld_q;
   assign bus.pk_dout     = dout_q;
   assign bus.pk_dout_cnt = dout_cnt_q;

   ddr3_gear_unpack #(
      .NARROW_W  (NARROW_W),
      .RATIO     (RATIO),
      .MSB_FIRST (MSB_FIRST)
   ) u_unpack (
      .ui_clk    (ui_clk),
      .rst       (rst),
      .din_vld   (bus.up_din_vld),
      .din       (bus.up_din),
      .din_rdy   (bus.up_din_rdy),
      .dout_vld  (bus.up_dout_vld),
      .dout      (bus.up_dout),
      .dout_last (bus.up_dout_last),
      .dout_rdy  (bus.up_dout_rdy)
   );

endmodule

// File: tb/tb_ddr3_gearbox.sv
// Randomised self-checking bench for ddr3_gearbox (MSB-first and LSB-first instances).
module tb_ddr3_gearbox;
   import ddr3_pkg::*;

   localparam int NW = 16;
   localparam int R  = 8;
   localparam int WW = NW * R;
   localparam int CW = clog2(R + 1);
   localparam int RW = WW + NW + CW + 5;
   localparam int RT_WORDS = 1000;

   logic ui_clk = 1'b0;
   logic rst    = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 ui_clk = ~ui_clk;

   ddr3_gearbox_if #(.NARROW_W(NW), .RATIO(R)) bm();
   ddr3_gearbox_if #(.NARROW_W(NW), .RATIO(R)) bl();

   ddr3_gearbox #(.NARROW_W(NW), .RATIO(R), .MSB_FIRST(1'b1)) dut_msb (
      .ui_clk (ui_clk),
      .rst    (rst),
      .bus    (bm.slave)
   );

   ddr3_gearbox #(.NARROW_W(NW), .RATIO(R), .MSB_FIRST(1'b0)) dut_lsb (
      .ui_clk (ui_clk),
      .rst    (rst),
      .bus    (bl.slave)
   );

   // Reference: where lane k of a word lives, by plain shifting.
   function automatic logic [WW-1:0] place(input logic [NW-1:0] v, input int k, input bit msb);
      logic [WW-1:0] w;
      w = WW'(v);
      return msb ? (w << ((R - 1 - k) * NW)) : (w << (k * NW));
   endfunction

   function automatic logic [WW-1:0] pack_model(input logic [NW-1:0] beats[$], input int n, input bit msb);
      logic [WW-1:0] w;
      w = '0;
      for (int k = 0; k < n; k++) w = w | place(beats[k], k, msb);
      return w;
   endfunction

   task automatic idle_inputs();
      bm.pk_din_vld = 1'b0; bm.pk_din = '0; bm.pk_flush = 1'b0; bm.pk_dout_rdy = 1'b1;
      bm.up_din_vld = 1'b0; bm.up_din = '0; bm.up_dout_rdy = 1'b1;
      bl.pk_din_vld = 1'b0; bl.pk_din = '0; bl.pk_flush = 1'b0; bl.pk_dout_rdy = 1'b1;
      bl.up_din_vld = 1'b0; bl.up_din = '0; bl.up_dout_rdy = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge ui_clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge ui_clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [RW-1:0] obs;
      logic [RW-1:0] exp;
      exp = RW'(3);
      @(negedge ui_clk);
      rst = 1'b1;
      idle_inputs();
      #1;
      obs = {bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, bm.up_dout_vld, bm.up_dout, bm.up_dout_last, bm.pk_din_rdy, bm.up_din_rdy};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL reset_msb: got %h expected %h", obs, exp); end
      obs = {bl.pk_dout_vld, bl.pk_dout, bl.pk_dout_cnt, bl.up_dout_vld, bl.up_dout, bl.up_dout_last, bl.pk_din_rdy, bl.up_din_rdy};
      compared++;
      if (obs !== exp) begin mismatched++; $display("FAIL reset_lsb: got %h expected %h", obs, exp); end
      @(negedge ui_clk);
      rst = 1'b0;
      #1;
      compared++;
      if ({bm.pk_din_rdy, bm.up_din_rdy} !== 2'b11) begin
         mismatched++; $display("FAIL reset_rdy_after: got %b expected 11", {bm.pk_din_rdy, bm.up_din_rdy});
      end
   endtask

   task automatic test_pack_basic();
      logic [NW-1:0] q[$];
      logic [WW-1:0] exp;
      do_reset();
      for (int k = 0; k < R; k++) begin
         @(negedge ui_clk);
         bm.pk_din_vld = 1'b1;
         bm.pk_din     = NW'(k + 1);
         q.push_back(NW'(k + 1));
         #1;
         compared++;
         if ({bm.pk_din_rdy, bm.pk_dout_vld} !== 2'b10) begin
            mismatched++; $display("FAIL pack_beat%0d rdy/vld: got %b expected 10", k, {bm.pk_din_rdy, bm.pk_dout_vld});
         end
      end
      exp = pack_model(q, R, 1'b1);
      @(negedge ui_clk);
      bm.pk_din_vld = 1'b0;
      #1;
      compared++;
      if ({bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt} !== {1'b1, exp, CW'(R)}) begin
         mismatched++; $display("FAIL pack_msb_word: got %b %h %0d expected 1 %h %0d", bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, exp, R);
      end
      @(negedge ui_clk);
      #1;
      compared++;
      if (bm.pk_dout_vld !== 1'b0) begin mismatched++; $display("FAIL pack_msb_drained: got %b expected 0", bm.pk_dout_vld); end
      // LSB-first placement with random lanes
      q.delete();
      for (int k = 0; k < R; k++) begin
         @(negedge ui_clk);
         bl.pk_din_vld = 1'b1;
         bl.pk_din     = NW'($urandom);
         q.push_back(bl.pk_din);
      end
      exp = pack_model(q, R, 1'b0);
      @(negedge ui_clk);
      bl.pk_din_vld = 1'b0;
      #1;
      compared++;
      if ({bl.pk_dout_vld, bl.pk_dout, bl.pk_dout_cnt} !== {1'b1, exp, CW'(R)}) begin
         mismatched++; $display("FAIL pack_lsb_word: got %b %h %0d expected 1 %h %0d", bl.pk_dout_vld, bl.pk_dout, bl.pk_dout_cnt, exp, R);
      end
   endtask

   task automatic test_flush();
      logic [NW-1:0] q[$];
      logic [WW-1:0] exp;
      logic [WW-1:0] w1;
      int            quiet;
      do_reset();
      q = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
      for (int k = 0; k < 3; k++) begin
         @(negedge ui_clk); bm.pk_din_vld = 1'b1; bm.pk_din = q[k];
      end
      @(negedge ui_clk); bm.pk_din_vld = 1'b0; bm.pk_flush = 1'b1;
      @(negedge ui_clk); bm.pk_flush = 1'b0;
      #1;
      exp = pack_model(q, 3, 1'b1);
      compared++;
      if ({bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt} !== {1'b1, exp, CW'(3)}) begin
         mismatched++; $display("FAIL flush_partial: got %b %h %0d expected 1 %h 3", bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, exp);
      end
      @(negedge ui_clk); bm.pk_flush = 1'b1;
      quiet = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge ui_clk); bm.pk_flush = 1'b0;
         #1;
         if (bm.pk_dout_vld) quiet++;
      end
      compared++;
      if (quiet !== 0) begin mismatched++; $display("FAIL flush_empty: got %0d valid cycles expected 0", quiet); end
      // flush coincident with the first beat of a word
      q.delete();
      @(negedge ui_clk); bm.pk_din_vld = 1'b1; bm.pk_din = NW'($urandom); bm.pk_flush = 1'b1;
      q.push_back(bm.pk_din);
      @(negedge ui_clk); bm.pk_din_vld = 1'b0; bm.pk_flush = 1'b0;
      #1;
      exp = pack_model(q, 1, 1'b1);
      compared++;
      if ({bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt} !== {1'b1, exp, CW'(1)}) begin
         mismatched++; $display("FAIL flush_with_beat: got %b %h %0d expected 1 %h 1", bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, exp);
      end
      // flush on the completing beat yields one normal word only
      q.delete();
      for (int k = 0; k < R; k++) begin
         @(negedge ui_clk); bm.pk_din_vld = 1'b1; bm.pk_din = NW'($urandom); bm.pk_flush = (k == R - 1);
         q.push_back(bm.pk_din);
      end
      @(negedge ui_clk); bm.pk_din_vld = 1'b0; bm.pk_flush = 1'b0;
      #1;
      exp = pack_model(q, R, 1'b1);
      compared++;
      if ({bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt} !== {1'b1, exp, CW'(R)}) begin
         mismatched++; $display("FAIL flush_on_full: got %b %h %0d expected 1 %h %0d", bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, exp, R);
      end
      @(negedge ui_clk); #1;
      compared++;
      if (bm.pk_dout_vld !== 1'b0) begin mismatched++; $display("FAIL flush_consumed: got %b expected 0", bm.pk_dout_vld); end
      // pending flush behind a stalled output
      q.delete();
      bm.pk_dout_rdy = 1'b0;
      for (int k = 0; k < R + 2; k++) begin
         @(negedge ui_clk); bm.pk_din_vld = 1'b1; bm.pk_din = NW'($urandom);
         q.push_back(bm.pk_din);
      end
      w1 = pack_model(q, R, 1'b1);
      @(negedge ui_clk); bm.pk_din_vld = 1'b0; bm.pk_flush = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge ui_clk); bm.pk_flush = 1'b0; bm.pk_din_vld = 1'b1; bm.pk_din = NW'($urandom);
         #1;
         compared++;
         if ({bm.pk_din_rdy, bm.pk_dout_vld, bm.pk_dout} !== {1'b0, 1'b1, w1}) begin
            mismatched++; $display("FAIL flush_pend_hold%0d: got %b %b %h expected 0 1 %h", c, bm.pk_din_rdy, bm.pk_dout_vld, bm.pk_dout, w1);
         end
      end
      @(negedge ui_clk); bm.pk_din_vld = 1'b0; bm.pk_dout_rdy = 1'b1;
      @(negedge ui_clk); #1;
      exp = place(q[R], 0, 1'b1) | place(q[R + 1], 1, 1'b1);
      compared++;
      if ({bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt} !== {1'b1, exp, CW'(2)}) begin
         mismatched++; $display("FAIL flush_pend_emit: got %b %h %0d expected 1 %h 2", bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, exp);
      end
   endtask

   task automatic test_stall();
      logic [NW-1:0] d[$];
      logic [WW-1:0] got[$];
      int            idx;
      do_reset();
      for (int k = 0; k < 2 * R; k++) d.push_back(NW'($urandom));
      bm.pk_dout_rdy = 1'b0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge ui_clk);
         bm.pk_din_vld = (idx < 2 * R);
         bm.pk_din     = d[idx % (2 * R)];
         #1;
         if (bm.pk_din_vld && bm.pk_din_rdy) idx++;
      end
      compared++;
      if ({idx, bm.pk_din_rdy} !== {32'(2 * R - 1), 1'b0}) begin
         mismatched++; $display("FAIL stall_absorb: got %0d beats rdy %b expected %0d rdy 0", idx, bm.pk_din_rdy, 2 * R - 1);
      end
      for (int c = 0; c < 40 && got.size() < 2; c++) begin
         @(negedge ui_clk);
         bm.pk_dout_rdy = 1'b1;
         bm.pk_din_vld  = (idx < 2 * R);
         bm.pk_din      = d[idx % (2 * R)];
         #1;
         if (bm.pk_din_vld && bm.pk_din_rdy) idx++;
         if (bm.pk_dout_vld && bm.pk_dout_rdy) got.push_back(bm.pk_dout);
      end
      @(negedge ui_clk); bm.pk_din_vld = 1'b0;
      compared++;
      if (got.size() != 2) begin
         mismatched++; $display("FAIL stall_words: got %0d words expected 2", got.size());
      end else begin
         compared++;
         if (got[0] !== pack_model(d[0:R-1], R, 1'b1)) begin
            mismatched++; $display("FAIL stall_word0: got %h expected %h", got[0], pack_model(d[0:R-1], R, 1'b1));
         end
         compared++;
         if (got[1] !== pack_model(d[R:2*R-1], R, 1'b1)) begin
            mismatched++; $display("FAIL stall_word1: got %h expected %h", got[1], pack_model(d[R:2*R-1], R, 1'b1));
         end
      end
   endtask

   task automatic test_unpack();
      logic [NW-1:0] lanes[$];
      logic [WW-1:0] words[2];
      int            acc_cyc[2];
      int            out_cyc[$];
      logic [NW-1:0] out_val[$];
      logic          out_last[$];
      int            wi;
      int            gaps;
      do_reset();
      for (int k = 0; k < R; k++) lanes.push_back(NW'(8'h11 * (k + 1)));
      for (int k = 0; k < R; k++) lanes.push_back(NW'($urandom));
      words[0] = pack_model(lanes[0:R-1], R, 1'b0);
      words[1] = pack_model(lanes[R:2*R-1], R, 1'b0);
      wi = 0;
      acc_cyc = '{-1, -1};
      for (int c = 0; c < 40 && out_val.size() < 2 * R; c++) begin
         @(negedge ui_clk);
         bl.up_din_vld = (wi < 2);
         bl.up_din     = words[wi % 2];
         #1;
         if (bl.up_din_vld && bl.up_din_rdy) begin acc_cyc[wi] = c; wi++; end
         if (bl.up_dout_vld && bl.up_dout_rdy) begin
            out_val.push_back(bl.up_dout); out_last.push_back(bl.up_dout_last); out_cyc.push_back(c);
         end
      end
      @(negedge ui_clk); bl.up_din_vld = 1'b0;
      compared++;
      if (out_val.size() != 2 * R) begin
         mismatched++; $display("FAIL unpack_count: got %0d beats expected %0d", out_val.size(), 2 * R);
      end else begin
         for (int n = 0; n < 2 * R; n++) begin
            compared++;
            if ({out_val[n], out_last[n]} !== {lanes[n], 1'((n % R) == R - 1)}) begin
               mismatched++; $display("FAIL unpack_lane%0d: got %h last %b expected %h last %b", n, out_val[n], out_last[n], lanes[n], (n % R) == R - 1);
            end
         end
         gaps = 0;
         for (int n = 1; n < 2 * R; n++) if (out_cyc[n] != out_cyc[n-1] + 1) gaps++;
         compared++;
         if ({gaps, out_cyc[0], acc_cyc[1]} !== {32'd0, 32'(acc_cyc[0] + 1), 32'(out_cyc[R-1])}) begin
            mismatched++; $display("FAIL unpack_timing: got gaps %0d first %0d acc1 %0d expected 0 %0d %0d", gaps, out_cyc[0], acc_cyc[1], acc_cyc[0] + 1, out_cyc[R-1]);
         end
      end
   endtask

   task automatic test_roundtrip();
      logic [NW-1:0] pk_model[$];
      logic [NW-1:0] up_model[$];
      logic [WW-1:0] wq[$];
      logic [NW-1:0] wb[$];
      logic [WW-1:0] exp;
      logic [WW+CW:0] prev_pk;
      logic [NW+1:0]  prev_up;
      logic          prev_pk_stall, prev_up_stall, pk_taken, up_taken;
      logic [NW-1:0] ebeat;
      int            sent, words_out, lanes_out;
      do_reset();
      sent = 0; words_out = 0; lanes_out = 0;
      pk_taken = 1'b0; up_taken = 1'b0; prev_pk_stall = 1'b0; prev_up_stall = 1'b0;
      prev_pk = '0; prev_up = '0;
      for (int c = 0; c < 40000 && lanes_out < RT_WORDS * R; c++) begin
         @(negedge ui_clk);
         if (pk_taken || !bm.pk_din_vld) begin
            bm.pk_din_vld = (sent < RT_WORDS * R) && ($urandom_range(3) != 0);
            bm.pk_din     = NW'($urandom);
         end
         if (up_taken || !bm.up_din_vld) begin
            bm.up_din_vld = 1'b0;
            if (wq.size() > 0 && $urandom_range(3) != 0) begin
               bm.up_din_vld = 1'b1;
               bm.up_din     = wq.pop_front();
            end
         end
         bm.pk_dout_rdy = ($urandom_range(3) != 0);
         bm.up_dout_rdy = ($urandom_range(3) != 0);
         #1;
         if (prev_pk_stall) begin
            compared++;
            if ({bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt} !== prev_pk) begin
               mismatched++; $display("FAIL rt_pk_hold: got %h expected %h", {bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt}, prev_pk);
            end
         end
         if (prev_up_stall) begin
            compared++;
            if ({bm.up_dout_vld, bm.up_dout, bm.up_dout_last} !== prev_up) begin
               mismatched++; $display("FAIL rt_up_hold: got %h expected %h", {bm.up_dout_vld, bm.up_dout, bm.up_dout_last}, prev_up);
            end
         end
         if (bm.pk_dout_vld && bm.pk_dout_rdy) begin
            wb.delete();
            for (int k = 0; k < R; k++) wb.push_back(pk_model.size() > 0 ? pk_model.pop_front() : 'x);
            exp = pack_model(wb, R, 1'b1);
            compared++;
            if ({bm.pk_dout, bm.pk_dout_cnt} !== {exp, CW'(R)}) begin
               mismatched++; $display("FAIL rt_word%0d: got %h %0d expected %h %0d", words_out, bm.pk_dout, bm.pk_dout_cnt, exp, R);
            end
            wq.push_back(bm.pk_dout);
            words_out++;
         end
         pk_taken = bm.pk_din_vld && bm.pk_din_rdy;
         if (pk_taken) begin
            pk_model.push_back(bm.pk_din); up_model.push_back(bm.pk_din); sent++;
         end
         up_taken = bm.up_din_vld && bm.up_din_rdy;
         if (bm.up_dout_vld && bm.up_dout_rdy) begin
            ebeat = (up_model.size() > 0) ? up_model.pop_front() : 'x;
            compared++;
            if ({bm.up_dout, bm.up_dout_last} !== {ebeat, 1'((lanes_out % R) == R - 1)}) begin
               mismatched++; $display("FAIL rt_lane%0d: got %h last %b expected %h last %b", lanes_out, bm.up_dout, bm.up_dout_last, ebeat, (lanes_out % R) == R - 1);
            end
            lanes_out++;
         end
         prev_pk_stall = bm.pk_dout_vld && !bm.pk_dout_rdy;
         prev_pk       = {bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt};
         prev_up_stall = bm.up_dout_vld && !bm.up_dout_rdy;
         prev_up       = {bm.up_dout_vld, bm.up_dout, bm.up_dout_last};
      end
      @(negedge ui_clk);
      bm.pk_din_vld = 1'b0; bm.up_din_vld = 1'b0; bm.pk_dout_rdy = 1'b1; bm.up_dout_rdy = 1'b1;
      compared++;
      if ({words_out, lanes_out, up_model.size()} !== {32'(RT_WORDS), 32'(RT_WORDS * R), 32'd0}) begin
         mismatched++; $display("FAIL rt_totals: got words %0d lanes %0d left %0d expected %0d %0d 0", words_out, lanes_out, up_model.size(), RT_WORDS, RT_WORDS * R);
      end
   endtask

   task automatic test_reset_mid();
      logic [WW-1:0] uw;
      logic [NW-1:0] q[$];
      logic [WW-1:0] exp;
      logic [RW-1:0] obs;
      int            noisy;
      do_reset();
      uw = {4{$urandom}};
      for (int c = 0; c < 5; c++) begin
         @(negedge ui_clk);
         bm.pk_din_vld  = 1'b1; bm.pk_din = NW'($urandom);
         bm.up_din_vld  = (c == 0); bm.up_din = uw;
         bm.up_dout_rdy = (c < 4);
      end
      @(negedge ui_clk);
      bm.pk_din_vld = 1'b0; bm.up_din_vld = 1'b0;
      #1;
      exp = uw >> ((R - 1 - 3) * NW);
      compared++;
      if ({bm.up_dout_vld, bm.up_dout} !== {1'b1, exp[NW-1:0]}) begin
         mismatched++; $display("FAIL rstmid_lane3: got %b %h expected 1 %h", bm.up_dout_vld, bm.up_dout, exp[NW-1:0]);
      end
      rst = 1'b1;
      #1;
      obs = {bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, bm.up_dout_vld, bm.up_dout, bm.up_dout_last, 2'b00};
      compared++;
      if (obs !== '0) begin mismatched++; $display("FAIL rstmid_zero: got %h expected 0", obs); end
      @(negedge ui_clk);
      rst = 1'b0; bm.up_dout_rdy = 1'b1;
      noisy = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge ui_clk); #1;
         if (bm.pk_dout_vld || bm.up_dout_vld) noisy++;
      end
      compared++;
      if (noisy !== 0) begin mismatched++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", noisy); end
      for (int k = 0; k < R; k++) begin
         @(negedge ui_clk); bm.pk_din_vld = 1'b1; bm.pk_din = NW'($urandom);
         q.push_back(bm.pk_din);
      end
      @(negedge ui_clk); bm.pk_din_vld = 1'b0;
      #1;
      exp = pack_model(q, R, 1'b1);
      compared++;
      if ({bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt} !== {1'b1, exp, CW'(R)}) begin
         mismatched++; $display("FAIL rstmid_clean: got %b %h %0d expected 1 %h %0d", bm.pk_dout_vld, bm.pk_dout, bm.pk_dout_cnt, exp, R);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_pack_basic();
      test_flush();
      test_stall();
      test_unpack();
      test_roundtrip();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ddr3_gearbox.md
DDR3_GEARBOX -- requirements
Module: ddr3_gearbox

Interface
REQ-001 Parameter NARROW_W, default 16, narrow lane width in bits.
REQ-002 Parameter RATIO, default 8, lanes per wide word; legal values 2, 4, 8, 16.
REQ-003 Parameter MSB_FIRST, default 1; 1 = first lane at top of the wide word, 0 = first lane at bit 0.
REQ-004 Derived constants: WIDE_W = NARROW_W*RATIO, CNT_W = clog2(RATIO+1).
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 Clock and reset ports:
- ui_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
REQ-007 Pack ports:
- pk_din_vld  in  1  narrow beat valid.
- pk_din  in  NARROW_W  narrow data.
- pk_din_rdy  out  1  narrow beat accepted when high with vld.
- pk_flush  in  1  single-cycle request to emit the partial word.
- pk_dout_vld  out  1  wide word valid.
- pk_dout  out  WIDE_W  packed word.
- pk_dout_cnt  out  CNT_W  count of valid lanes in pk_dout.
- pk_dout_rdy  in  1  downstream accepts the wide word.
REQ-008 Unpack ports:
- up_din_vld  in  1  wide word valid.
- up_din  in  WIDE_W  wide data.
- up_din_rdy  out  1  wide word accepted.
- up_dout_vld  out  1  narrow beat valid.
- up_dout  out  NARROW_W  narrow data.
- up_dout_last  out  1  high on the final lane of a word.
- up_dout_rdy  in  1  downstream accepts the narrow beat.

Function
REQ-009 A transfer occurs on any interface only in a cycle where vld and rdy are both high at the ui_clk rising edge.
REQ-010 Pack lane counter counts 0..RATIO-1 and wraps to 0 on the beat that completes a word.
REQ-011 Pack lane placement: lane k goes to bits [WIDE_W-1-k*NARROW_W -: NARROW_W] when MSB_FIRST=1, and to [k*NARROW_W +: NARROW_W] when MSB_FIRST=0.
REQ-012 pk_dout_vld rises one cycle after the completing beat; pk_dout_cnt = RATIO for a full word.
REQ-013 pk_dout, pk_dout_cnt and pk_dout_vld hold stable while pk_dout_rdy is low.
REQ-014 pk_din_rdy = (!flush_pend and cnt != RATIO-1) or !pk_dout_vld or pk_dout_rdy; lane counts below RATIO-1 are absorbed while the output stalls.
REQ-015 Flush with cnt = 0 and no beat in the same cycle is ignored and produces no output.
REQ-016 Flush with cnt > 0: emit the partial word, pad unused lanes with zero, pk_dout_cnt = cnt, reset the counter.
REQ-017 Flush coincident with an accepted beat includes that beat first; if that beat completes the word, a normal full word is emitted and the flush is consumed.
REQ-018 Flush while the output register is occupied and not draining sets flush_pend; pk_din_rdy is low while flush_pend is set; the pending flush executes on the first cycle the output frees.
REQ-019 up_din_rdy = !busy, or the last lane is transferring this cycle, so back-to-back words stream with zero bubbles.
REQ-020 up_dout_vld rises one cycle after a wide word is accepted.
REQ-021 Unpack emits lanes in the same order as REQ-011; up_dout_last is high on lane RATIO-1 only.
REQ-022 up_dout and up_dout_last hold stable while up_dout_rdy is low.
REQ-023 The pack and unpack paths are fully independent; simultaneous activity on both never interacts.
REQ-024 Sustained throughput is one narrow beat per cycle per path.

Reset
REQ-025 While rst is high, all of the following are 0: vld outputs, counters, flush_pend, pk_dout, pk_dout_cnt, up_dout, up_dout_last.
REQ-026 pk_din_rdy and up_din_rdy are 1 after reset.
REQ-027 Reset mid-word discards the partial pack word and the remaining unpack lanes; nothing is emitted after rst falls until new input arrives.

Structure
REQ-028 Shared package ddr3_pkg holds the default NARROW_W/RATIO constants and the clog2 function used for CNT_W.
REQ-029 The unpack path is the sub-module ddr3_gear_unpack, instantiated once; the pack path stays in the top level.

Verification
REQ-030 Scenario: 8 beats 0x0001..0x0008, MSB_FIRST=1, rdy=1 -> pk_dout = 0x0001_0002_..._0008, cnt = 8, one cycle after beat 8.
REQ-031 Scenario: 3 beats 0xA0A0, 0xB1B1, 0xC2C2, then flush -> pk_dout = 0xA0A0_B1B1_C2C2_0000_..._0000, cnt = 3; a following flush with cnt = 0 produces nothing.
REQ-032 Scenario: pk_dout_rdy held low 20 cycles while 16 beats are offered -> 7 beats of the next word are absorbed, then pk_din_rdy drops; words emerge in order when rdy releases.
REQ-033 Scenario: 0x0011..0x0088 unpacked, MSB_FIRST=0, up_dout_rdy=1 -> lanes 0x0088 first? No: lane 0 = bits [15:0]; up_dout_last asserts on the 8th beat; a second word streams with no gap.
REQ-034 Scenario: random up_dout_rdy and pk_dout_rdy toggling, 1000 words -> round-trip pack into unpack is bit-exact and no beat is lost or duplicated.
REQ-035 Scenario: rst asserted after beat 5 of a pack word and during lane 3 of an unpack word -> all outputs 0; the next 8 beats form a clean word.
